max7219_sequencer: RTL and testbench
====================================

Name: max7219_sequencer

Overview:
Command scheduler and serializer for the calculator's MAX7219 8-digit display. After reset it runs the mandatory MAX7219 init sequence. It then accepts two kinds of request from the calculator FSM: digit-frame updates (operand/result value plus decimal point) and brightness changes. It arbitrates between them and serializes each 16-bit register write onto sck/cs/din.

Parameters:
DIGIT_NUM, 8, number of BCD digits driven (1..8); also sets the scan-limit value.
CLK_DIV, 4, system clocks per SCK half-period (>=1).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low
upd_req  in  1  request a digit-frame write; num/dp_en/dp sampled in the same cycle
num  in  DIGIT_NUM*4  BCD digits; num[3:0] is the LSD (MAX7219 digit 1)
dp_en  in  1  decimal point enabled
dp  in  3  DP digit index; 0 = LSD
upd_ack  out  1  one-cycle pulse, the cycle after upd_req is captured
bright_req  in  1  request an intensity write; brightness sampled in the same cycle
brightness  in  4  intensity 0..15
busy  out  1  high while not idle or any request is pending
init_done  out  1  high once the init sequence has completed
sck  out  1  MAX7219 CLK
cs  out  1  MAX7219 LOAD/CS, active-low
din  out  1  MAX7219 DIN

Behaviour:
- Reset (reset=0 at a clock edge): next cycle cs=1, sck=0, din=0, upd_ack=0, init_done=0, busy=1.
  - Pending flags cleared, stored brightness=0, snapshot num=0.
  - Any word in flight is abandoned with no partial load, since cs is forced high.
  - Init restarts when reset is released.
- Word format: {4'h0, addr[3:0], data[7:0]}, shifted MSB first.
- Word timing, total 34*CLK_DIV clocks:
  - CS_SETUP: cs=0, sck=0, din=bit15, for CLK_DIV clocks.
  - Per bit 15..0: HIGH phase (sck=1, CLK_DIV clocks), then LOW phase (sck=0, CLK_DIV clocks).
  - din changes only at the start of a LOW phase, to the next bit.
  - After bit0's LOW phase: cs=1 GAP for CLK_DIV clocks. din=0 in GAP and idle.
- States: RESET_INIT, INIT_WORD, IDLE, BRIGHT_WORD, FRAME_WORD.
- Init sequence, in order; init_done rises in the cycle after the last GAP:
  - 0x0F00 (display test off)
  - 0x0B00|(DIGIT_NUM-1) (scan limit)
  - 0x09FF (Code-B decode all digits)
  - 0x0A00|stored brightness (intensity)
  - 0x0C01 (normal operation)
- Request capture, active in every state including init:
  - upd_req=1: snapshot num/dp_en/dp, set frame_pend, pulse upd_ack next cycle.
  - bright_req=1: store brightness, set bright_pend.
  - Latest request wins; snapshots overwrite each other.
  - upd_req held high is captured, and acked, every cycle.
- Arbitration is evaluated only in IDLE, after init_done:
  - bright_pend has priority. It issues one word 0x0A0|brightness and clears the flag at word start.
  - Otherwise frame_pend starts a frame and clears the flag at frame start.
- Frame: DIGIT_NUM words, addresses 1..DIGIT_NUM in ascending order.
  - Data = {dp_bit, 3'b000, nibble}, where nibble = snapshot[4k+3:4k] for address k+1.
  - dp_bit=1 only when dp_en=1 and dp==k. dp >= DIGIT_NUM yields no DP.
  - A frame is atomic and uses the snapshot latched at frame start (a working copy). New requests during the frame only set pend flags.
  - After the frame the FSM returns to IDLE, so a pending brightness request goes before a re-queued frame.
- busy = (state != IDLE) | frame_pend | bright_pend.
- Back-to-back words have no extra idle cycles beyond GAP.
- Simultaneous upd_req and bright_req: both are captured, and brightness is served first.

Test Plan:
- Release reset with CLK_DIV=1 and DIGIT_NUM=8 -> exactly 5 words decoded from sck rising edges: 0x0F00, 0x0B07, 0x09FF, 0x0A00, 0x0C01. Each word spans 34 clocks with cs low for 33; init_done rises after the 5th GAP.
- After init, upd_req with num=0x12345678, dp_en=1, dp=2 -> upd_ack one cycle later. Words in order: 0x0108, 0x0207, 0x0386, 0x0405, 0x0504, 0x0603, 0x0702, 0x0801. busy falls after the last GAP.
- In IDLE, upd_req and bright_req(brightness=9) in the same cycle -> 0x0A09 first, then the 8-word frame.
- Mid-frame (during the 3rd word), upd_req with num=0 -> current frame completes with the old data, then a second frame of 0x0100..0x0800.
- Reset asserted during bit 7 of a frame word -> cs=1, sck=0 next cycle. No further words until reset is released, then the full init sequence replays and the pending frame is discarded.
- CLK_DIV=4 -> each sck half-period is 4 clocks and one word spans 136 clocks. din is stable for at least 4 clocks around every sck rising edge.

Source files
------------

// File: rtl/max7219_sequencer_if.sv
// Request/response and serial-pin bundle for the MAX7219 display sequencer.
//   master : calculator side; drives upd_req/num/dp_en/dp and bright_req/brightness,
//            observes upd_ack, busy, init_done and the serial pins.
//   slave  : sequencer side; the mirror image of master.
// Signals:
//   upd_req, num[DIGIT_NUM*4-1:0], dp_en, dp[2:0] -> digit-frame request
//   upd_ack                                       <- one-cycle capture acknowledge
//   bright_req, brightness[3:0]                   -> intensity request
//   busy, init_done                               <- status
//   sck, cs, din                                  <- MAX7219 CLK, LOAD (active-low), DIN
interface max7219_sequencer_if #(
    parameter int DIGIT_NUM = 8
);
    logic                     upd_req;
    logic [DIGIT_NUM*4-1:0]   num;
    logic                     dp_en;
    logic [2:0]               dp;
    logic                     upd_ack;
    logic                     bright_req;
    logic [3:0]               brightness;
    logic                     busy;
    logic                     init_done;
    logic                     sck;
    logic                     cs;
    logic                     din;

    modport master (
        output upd_req, num, dp_en, dp, bright_req, brightness,
        input  upd_ack, busy, init_done, sck, cs, din
    );

    modport slave (
        input  upd_req, num, dp_en, dp, bright_req, brightness,
        output upd_ack, busy, init_done, sck, cs, din
    );
endinterface

// File: rtl/max7219_sequencer.sv
// Command scheduler and serializer for an 8-digit MAX7219 display.
// After reset it sends the init sequence, then serves brightness writes (priority)
// and digit-frame writes, serializing each 16-bit word MSB first on sck/cs/din.
// Ports:
//   clock : system clock
//   reset : synchronous, active-low
//   bus   : max7219_sequencer_if.slave (requests, status, serial pins)
// Parameters:
//   DIGIT_NUM : digits driven (1..8), also the scan-limit value
//   CLK_DIV   : system clocks per SCK half-period (>=1)
module max7219_sequencer #(
    parameter int DIGIT_NUM = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic                clock,
    input  logic                reset,
    max7219_sequencer_if.slave  bus
);
    localparam int           NUM_W    = DIGIT_NUM * 4;
    localparam int           DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [2:0]   LAST_DIG = 3'(DIGIT_NUM - 1);

    typedef enum logic [2:0] {RESET_INIT, INIT_WORD, IDLE, BRIGHT_WORD, FRAME_WORD} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_LOW, PH_GAP} phase_t;

    state_t             state, state_n;
    logic [2:0]         idx, idx_n;
    logic               init_done_r, init_done_n;
    logic               frame_pend, bright_pend;
    logic [3:0]         bright_val;
    logic [NUM_W-1:0]   snap_num, work_num;
    logic               snap_dp_en, work_dp_en;
    logic [2:0]         snap_dp, work_dp;
    logic               upd_ack_r;
    logic               word_start, word_done, clr_bright, clr_frame, load_work;
    logic [15:0]        word_next;

    logic               wactive;
    phase_t             wphase;
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         bit_cnt;
    logic [15:0]        shreg;
    logic               div_end;

    function automatic logic [15:0] init_word(input logic [2:0] k, input logic [3:0] b);
        case (k)
            3'd0:    return 16'h0F00;
            3'd1:    return {8'h0B, 8'(DIGIT_NUM - 1)};
            3'd2:    return 16'h09FF;
            3'd3:    return {12'h0A0, b};
            default: return 16'h0C01;
        endcase
    endfunction

    function automatic logic [15:0] frame_word(input logic [2:0] k, input logic [NUM_W-1:0] n,
                                               input logic en, input logic [2:0] p);
        logic [NUM_W-1:0] sh;
        sh = n >> (4 * k);
        return {4'h0, {1'b0, k} + 4'd1, (en && (p == k)), 3'b000, sh[3:0]};
    endfunction

    assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign word_done = wactive && (wphase == PH_GAP) && div_end;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= RESET_INIT;
            idx         <= 3'd0;
            init_done_r <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            init_done_r <= init_done_n;
        end
    end

    // The next word is launched in the same cycle the previous GAP ends, so
    // words inside a sequence run back to back.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        init_done_n = init_done_r;
        word_start  = 1'b0;
        word_next   = 16'h0000;
        clr_bright  = 1'b0;
        clr_frame   = 1'b0;
        load_work   = 1'b0;
        case (state)
            RESET_INIT: begin
                state_n    = INIT_WORD;
                idx_n      = 3'd0;
                word_start = 1'b1;
                word_next  = init_word(3'd0, bright_val);
            end
            INIT_WORD: begin
                if (word_done) begin
                    if (idx == 3'd4) begin
                        state_n     = IDLE;
                        init_done_n = 1'b1;
                    end else begin
                        idx_n      = idx + 3'd1;
                        word_start = 1'b1;
                        word_next  = init_word(idx + 3'd1, bright_val);
                    end
                end
            end
            IDLE: begin
                if (bright_pend) begin
                    state_n    = BRIGHT_WORD;
                    word_start = 1'b1;
                    word_next  = {12'h0A0, bright_val};
                    clr_bright = 1'b1;
                end else if (frame_pend) begin
                    state_n    = FRAME_WORD;
                    idx_n      = 3'd0;
                    word_start = 1'b1;
                    word_next  = frame_word(3'd0, snap_num, snap_dp_en, snap_dp);
                    clr_frame  = 1'b1;
                    load_work  = 1'b1;
                end
            end
            BRIGHT_WORD: begin
                if (word_done) state_n = IDLE;
            end
            FRAME_WORD: begin
                if (word_done) begin
                    if (idx == LAST_DIG) begin
                        state_n = IDLE;
                    end else begin
                        idx_n      = idx + 3'd1;
                        word_start = 1'b1;
                        word_next  = frame_word(idx + 3'd1, work_num, work_dp_en, work_dp);
                    end
                end
            end
            default: state_n = RESET_INIT;
        endcase
    end

    // A request arriving in the same cycle its flag is cleared stays pending.
    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_pend  <= 1'b0;
            bright_pend <= 1'b0;
            bright_val  <= 4'd0;
            snap_num    <= '0;
            snap_dp_en  <= 1'b0;
            snap_dp     <= 3'd0;
            upd_ack_r   <= 1'b0;
        end else begin
            upd_ack_r <= bus.upd_req;
            if (clr_frame)  frame_pend  <= 1'b0;
            if (clr_bright) bright_pend <= 1'b0;
            if (bus.upd_req) begin
                frame_pend <= 1'b1;
                snap_num   <= bus.num;
                snap_dp_en <= bus.dp_en;
                snap_dp    <= bus.dp;
            end
            if (bus.bright_req) begin
                bright_pend <= 1'b1;
                bright_val  <= bus.brightness;
            end
        end
    end

    // Working copy keeps a frame atomic against new requests.
    always_ff @(posedge clock) begin
        if (load_work) begin
            work_num   <= snap_num;
            work_dp_en <= snap_dp_en;
            work_dp    <= snap_dp;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wactive <= 1'b0;
            wphase  <= PH_SETUP;
            div_cnt <= '0;
            bit_cnt <= 4'd0;
        end else if (word_start) begin
            wactive <= 1'b1;
            wphase  <= PH_SETUP;
            div_cnt <= '0;
            bit_cnt <= 4'd15;
        end else if (wactive) begin
            if (div_end) begin
                div_cnt <= '0;
                case (wphase)
                    PH_SETUP: wphase <= PH_HIGH;
                    PH_HIGH:  wphase <= PH_LOW;
                    PH_LOW: begin
                        if (bit_cnt == 4'd0) begin
                            wphase <= PH_GAP;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                            wphase  <= PH_HIGH;
                        end
                    end
                    default: wactive <= 1'b0;
                endcase
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // din follows shreg[15]; shifting at the HIGH->LOW boundary moves din to the
    // next bit exactly at the start of each LOW phase.
    always_ff @(posedge clock) begin
        if (word_start) begin
            shreg <= word_next;
        end else if (wactive && div_end && (wphase == PH_HIGH)) begin
            shreg <= {shreg[14:0], 1'b0};
        end
    end

    assign bus.cs        = !(wactive && (wphase != PH_GAP));
    assign bus.sck       = wactive && (wphase == PH_HIGH);
    assign bus.din       = wactive && (wphase != PH_GAP) && shreg[15];
    assign bus.busy      = (state != IDLE) || frame_pend || bright_pend;
    assign bus.init_done = init_done_r;
    assign bus.upd_ack   = upd_ack_r;
endmodule

// File: tb/tb_max7219_sequencer.sv
// Self-checking bench for max7219_sequencer: two instances (CLK_DIV=1 and 4) share
// one stimulus stream; each is compared every cycle against a job/offset model, and
// words decoded from the CLK_DIV=1 pins are checked against hand-written lists.
module tb_max7219_sequencer;
    localparam int DN = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        upd_req;
    logic [31:0] num;
    logic        dp_en;
    logic [2:0]  dp;
    logic        bright_req;
    logic [3:0]  brightness;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_word(input int k, input logic [3:0] b);
        case (k)
            0:       return 16'h0F00;
            1:       return 16'h0B00 | 16'(DN - 1);
            2:       return 16'h09FF;
            3:       return {12'h0A0, b};
            default: return 16'h0C01;
        endcase
    endfunction

    function automatic logic [15:0] frame_word(input int k, input logic [31:0] n,
                                               input logic en, input logic [2:0] p);
        logic [31:0] sh;
        logic [7:0]  data;
        sh   = n >> (4 * k);
        data = {4'h0, sh[3:0]};
        if (en && (int'(p) == k)) data[7] = 1'b1;
        return {8'(k + 1), data};
    endfunction

    // Expected {cs, sck, din} at cycle t of a word with half-period d.
    function automatic logic [2:0] wire_bits(input logic [15:0] w, input int t, input int d);
        int u, b;
        if (t < d) return {2'b00, w[15]};
        if (t >= 33 * d) return 3'b100;
        u = t - d;
        b = u / (2 * d);
        if ((u % (2 * d)) < d) return {2'b01, w[15 - b]};
        if (b < 15) return {2'b00, w[14 - b]};
        return 3'b000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int D = (g == 0) ? 1 : 4;

        max7219_sequencer_if #(.DIGIT_NUM(DN)) bus();

        assign bus.upd_req    = upd_req;
        assign bus.num        = num;
        assign bus.dp_en      = dp_en;
        assign bus.dp         = dp;
        assign bus.bright_req = bright_req;
        assign bus.brightness = brightness;

        max7219_sequencer #(.DIGIT_NUM(DN), .CLK_DIV(D)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        // job: 0 none, 1 init, 2 brightness, 3 frame; m_t = cycle within current word
        logic        m_rst   = 1'b1;
        int          m_job   = 0;
        int          m_idx   = 0;
        int          m_t     = 0;
        logic [15:0] m_word  = 16'h0;
        logic        m_fp    = 1'b0;
        logic        m_bp    = 1'b0;
        logic        m_done  = 1'b0;
        logic        m_ack   = 1'b0;
        logic [3:0]  m_br    = 4'h0;
        logic [31:0] m_snap  = 32'h0;
        logic [31:0] m_work  = 32'h0;
        logic        m_sen   = 1'b0;
        logic        m_wen   = 1'b0;
        logic [2:0]  m_sdp   = 3'h0;
        logic [2:0]  m_wdp   = 3'h0;
        logic        started = 1'b0;
        int          hi_run  = 0;

        always @(posedge clock) begin
            int last;
            started = 1'b1;
            if (!reset) begin
                m_rst = 1'b1; m_job = 0; m_fp = 1'b0; m_bp = 1'b0; m_br = 4'h0;
                m_snap = 32'h0; m_sen = 1'b0; m_sdp = 3'h0; m_done = 1'b0; m_ack = 1'b0;
            end else begin
                m_ack = upd_req;
                last  = (m_job == 1) ? 4 : (m_job == 2) ? 0 : DN - 1;
                if (m_rst) begin
                    m_rst = 1'b0; m_job = 1; m_idx = 0; m_t = 0;
                    m_word = init_word(0, m_br);
                end else if (m_job != 0) begin
                    if (m_t == 34 * D - 1) begin
                        if (m_idx == last) begin
                            if (m_job == 1) m_done = 1'b1;
                            m_job = 0;
                        end else begin
                            m_idx++;
                            m_t = 0;
                            m_word = (m_job == 1) ? init_word(m_idx, m_br)
                                                  : frame_word(m_idx, m_work, m_wen, m_wdp);
                        end
                    end else begin
                        m_t++;
                    end
                end else if (m_done) begin
                    if (m_bp) begin
                        m_job = 2; m_idx = 0; m_t = 0; m_word = {12'h0A0, m_br}; m_bp = 1'b0;
                    end else if (m_fp) begin
                        m_work = m_snap; m_wen = m_sen; m_wdp = m_sdp;
                        m_job = 3; m_idx = 0; m_t = 0;
                        m_word = frame_word(0, m_work, m_wen, m_wdp); m_fp = 1'b0;
                    end
                end
                if (upd_req) begin
                    m_snap = num; m_sen = dp_en; m_sdp = dp; m_fp = 1'b1;
                end
                if (bright_req) begin
                    m_br = brightness; m_bp = 1'b1;
                end
            end
        end

        always @(negedge clock) begin
            logic [2:0] w;
            logic [5:0] e, a;
            if (started) begin
                w = (m_job != 0) ? wire_bits(m_word, m_t, D) : 3'b100;
                e = {w, m_rst || (m_job != 0) || m_fp || m_bp, m_done, m_ack};
                a = {bus.cs, bus.sck, bus.din, bus.busy, bus.init_done, bus.upd_ack};
                chk($sformatf("outputs clkdiv=%0d {cs,sck,din,busy,init_done,upd_ack}", D),
                    32'(a), 32'(e));
                if (D == 4) begin
                    if (!reset) begin
                        hi_run = 0;
                    end else if (bus.sck) begin
                        hi_run++;
                    end else begin
                        if (hi_run != 0) chk("sck high width clkdiv=4", 32'(hi_run), 32'd4);
                        hi_run = 0;
                    end
                end
            end
        end
    end

    wire cs0   = inst[0].bus.cs;
    wire sck0  = inst[0].bus.sck;
    wire din0  = inst[0].bus.din;
    wire busy0 = inst[0].bus.busy;
    wire done0 = inst[0].bus.init_done;
    wire ack0  = inst[0].bus.upd_ack;
    wire busy1 = inst[1].bus.busy;
    wire done1 = inst[1].bus.init_done;

    // Word decoder on the CLK_DIV=1 pins: shift din on sck rise, emit on cs rise.
    logic [15:0] dec_q[$];
    int          low_q[$];
    logic [15:0] dsh      = 16'h0;
    int          dbits    = 0;
    int          dlow     = 0;
    logic        prev_sck = 1'b0;
    logic        prev_cs  = 1'b1;

    always @(negedge clock) begin
        if (cs0 === 1'b1) begin
            if (prev_cs == 1'b0 && dbits == 16) begin
                dec_q.push_back(dsh);
                low_q.push_back(dlow);
            end
            dbits = 0;
            dlow  = 0;
        end else if (cs0 === 1'b0) begin
            dlow++;
            if (sck0 === 1'b1 && prev_sck == 1'b0) begin
                dsh = {dsh[14:0], din0};
                dbits++;
            end
        end
        prev_sck = (sck0 === 1'b1);
        prev_cs  = (cs0 !== 1'b0);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_upd(input logic [31:0] n, input logic en, input logic [2:0] p);
        upd_req = 1'b1; num = n; dp_en = en; dp = p;
        step();
        upd_req = 1'b0;
    endtask

    task automatic wait_idle0(input string name, input int budget);
        int n = 0;
        while (!(done0 && !busy0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk({name, " wait timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_words(input int cnt, input int budget);
        int n = 0;
        while (dec_q.size() < cnt && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("decoded word wait timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_words(input string name, input logic [15:0] e[$]);
        chk({name, " word count"}, 32'(dec_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < dec_q.size()) chk($sformatf("%s word%0d", name, i), 32'(dec_q[i]), 32'(e[i]));
        end
        dec_q.delete();
        low_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_q[$];
        int          n;

        reset = 1'b0; upd_req = 1'b0; num = 32'h0; dp_en = 1'b0; dp = 3'h0;
        bright_req = 1'b0; brightness = 4'h0;
        repeat (3) step();
        chk("reset state {cs,sck,din,upd_ack,init_done,busy}",
            32'({cs0, sck0, din0, ack0, done0, busy0}), 32'b100001);

        // Init sequence: 5 words x 34 clocks, init_done one cycle after last GAP
        dec_q.delete();
        low_q.delete();
        reset = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!done0 && n < 2000);
        chk("init_done latency", 32'(n), 32'd171);
        for (int i = 0; i < low_q.size(); i++) chk($sformatf("init cs-low clocks word%0d", i),
                                                   32'(low_q[i]), 32'd33);
        exp_q = '{16'h0F00, 16'h0B07, 16'h09FF, 16'h0A00, 16'h0C01};
        chk_words("init", exp_q);

        // Single frame with a decimal point on digit index 2
        pulse_upd(32'h12345678, 1'b1, 3'd2);
        chk("upd_ack pulse", 32'(ack0), 32'd1);
        step();
        chk("upd_ack clears", 32'(ack0), 32'd0);
        wait_idle0("frame", 2000);
        exp_q = '{16'h0108, 16'h0207, 16'h0386, 16'h0405, 16'h0504, 16'h0603, 16'h0702, 16'h0801};
        chk_words("frame", exp_q);

        // Simultaneous requests: brightness goes first
        upd_req = 1'b1; num = 32'h12345678; dp_en = 1'b0; dp = 3'd0;
        bright_req = 1'b1; brightness = 4'd9;
        step();
        upd_req = 1'b0; bright_req = 1'b0;
        wait_idle0("bright+frame", 2000);
        exp_q = '{16'h0A09, 16'h0108, 16'h0207, 16'h0306, 16'h0405, 16'h0504, 16'h0603,
                  16'h0702, 16'h0801};
        chk_words("bright+frame", exp_q);

        // New frame requested during the 3rd word: old frame finishes, then the new one
        pulse_upd(32'h12345678, 1'b1, 3'd2);
        wait_words(2, 500);
        repeat (5) step();
        pulse_upd(32'h00000000, 1'b0, 3'd0);
        wait_idle0("requeue", 3000);
        exp_q = '{16'h0108, 16'h0207, 16'h0386, 16'h0405, 16'h0504, 16'h0603, 16'h0702, 16'h0801,
                  16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
        chk_words("requeue", exp_q);

        // Reset in the middle of a frame word, with another frame pending
        pulse_upd(32'h87654321, 1'b0, 3'd0);
        wait_words(1, 500);
        repeat (17) step();
        pulse_upd(32'h11111111, 1'b1, 3'd5);
        reset = 1'b0;
        step();
        chk("abort {cs,sck}", 32'({cs0, sck0}), 32'b10);
        repeat (4) step();
        chk("no words during reset", 32'(dec_q.size()), 32'd1);
        dec_q.delete();
        low_q.delete();
        reset = 1'b1;
        wait_idle0("reinit", 2000);
        exp_q = '{16'h0F00, 16'h0B07, 16'h09FF, 16'h0A00, 16'h0C01};
        chk_words("reinit", exp_q);
        repeat (40) step();
        chk("pending frame discarded by reset", 32'({busy0, 1'b0}) | 32'(dec_q.size()), 32'd0);

        // Randomized traffic, including held upd_req and occasional resets
        for (int c = 0; c < 4000; c++) begin
            if (c >= 1500 && c < 1520) upd_req = 1'b1;
            else upd_req = ($urandom_range(0, 29) == 0);
            num        = $urandom;
            dp_en      = 1'($urandom);
            dp         = 3'($urandom);
            bright_req = ($urandom_range(0, 39) == 0);
            brightness = 4'($urandom);
            reset      = ($urandom_range(0, 1499) != 0);
            step();
        end
        upd_req = 1'b0; bright_req = 1'b0; reset = 1'b1;
        n = 0;
        while (!(done0 && !busy0 && done1 && !busy1) && n < 8000) begin
            step();
            n++;
        end
        if (n >= 8000) chk("final idle wait timeout", 32'd1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
